// File: rtl/seq_arrdiv_ctrl.sv
// Iterative unsigned restoring divider: one subtract/restore row reused over WIDTH cycles.
// Optional macro ARRDIV_DBZ_EN adds a dbz port and a divide-by-zero shortcut.
module seq_arrdiv_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
`ifdef ARRDIV_DBZ_EN
  ,
  output logic             dbz
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef ARRDIV_DBZ_EN
  logic             dbz_q, dbz_d;
`endif

  logic [WIDTH:0]   row_s;
  logic [WIDTH:0]   row_diff;
  logic             row_borrow;
  logic [WIDTH-1:0] row_r;
  logic [WIDTH-1:0] row_a;

  // Single restoring row; quotient bits shift into the dividend register's LSB.
  always_comb begin
    row_s      = {r_q, a_q[WIDTH-1]};
    row_diff   = row_s - {1'b0, b_q};
    row_borrow = row_diff[WIDTH];
    row_r      = row_borrow ? row_s[WIDTH-1:0] : row_diff[WIDTH-1:0];
    row_a      = {a_q[WIDTH-2:0], ~row_borrow};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ARRDIV_DBZ_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ARRDIV_DBZ_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_CALC;
`ifdef ARRDIV_DBZ_EN
          if (b == '0) state_d = S_DONE;
`endif
        end
      end
      S_CALC:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates and registered handshake outputs
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
`ifdef ARRDIV_DBZ_EN
    dbz_d       = dbz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          r_d   = '0;
          cnt_d = CW'(WIDTH - 1);
`ifdef ARRDIV_DBZ_EN
          dbz_d = 1'b0;
          if (b == '0) begin
            quot_d = '1;
            rem_d  = a;
            dbz_d  = 1'b1;
          end
`endif
        end
      end
      S_CALC: begin
        a_d   = row_a;
        r_d   = row_r;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quot_d = row_a;
          rem_d  = row_r;
        end
      end
      S_DONE: begin
`ifdef ARRDIV_DBZ_EN
        if (out_ready) dbz_d = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
`ifdef ARRDIV_DBZ_EN
  assign dbz       = dbz_q;
`endif

endmodule
